// File: rtl/frequency_analyzer_sync_multi.sv
`default_nettype none
// ============================================================================
// Module   : frequency_analyzer_sync_multi
// Purpose  : Round-robin start/stop gate sequencer for CHANNELS analyzers.
// Revision : 1.0 - initial release
// ============================================================================
module frequency_analyzer_sync_multi #(
    parameter int CLOCK        = 100000000,
    parameter int FREQUENCY    = 2000,
    parameter int CHANNELS     = 4,
    parameter int SIGNAL_DELAY = 20,
    parameter int CNT_W        = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        continuous,
    input  logic                        trigger,
    input  logic                        period_load,
    input  logic [CNT_W-1:0]            period_value,
    output logic [CHANNELS-1:0]         start_analyzer,
    output logic [CHANNELS-1:0]         stop_analyzer,
    output logic [$clog2(CHANNELS)-1:0] active_channel,
    output logic                        busy,
    output logic                        done
);

    localparam int c_SLOT_W = $clog2(CHANNELS + 1);
    localparam int c_CH_W   = $clog2(CHANNELS);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STROBE = 2'd1;
    localparam logic [1:0] c_GAP    = 2'd2;

    localparam logic [CNT_W-1:0] c_MIN_PERIOD   = CNT_W'(SIGNAL_DELAY + 1);
    localparam logic [CNT_W-1:0] c_STROBE_END   = CNT_W'(SIGNAL_DELAY - 1);
    localparam logic [CNT_W-1:0] c_RAW_PERIOD   = CNT_W'(CLOCK / FREQUENCY);
    localparam logic [CNT_W-1:0] c_RESET_PERIOD = (c_RAW_PERIOD < c_MIN_PERIOD) ?
                                                  c_MIN_PERIOD : c_RAW_PERIOD;
    localparam logic [c_SLOT_W-1:0] c_FINAL_SLOT = c_SLOT_W'(CHANNELS);
    localparam logic [c_SLOT_W-1:0] c_LAST_CH    = c_SLOT_W'(CHANNELS - 1);
    localparam logic [c_CH_W-1:0]   c_LAST_ACT   = c_CH_W'(CHANNELS - 1);
    localparam logic [CHANNELS-1:0] c_ONE        = CHANNELS'(1);

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_tcnt;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    r_shadow;
    logic [c_SLOT_W-1:0] r_slot;
    logic                r_first;
    logic                r_mode;

    logic [CNT_W-1:0]    w_load_clamped;
    logic [CNT_W-1:0]    w_next_period;
    logic [CNT_W-1:0]    w_period_last;
    logic [c_SLOT_W-1:0] w_prev_slot;
    logic [CHANNELS-1:0] w_start;
    logic [CHANNELS-1:0] w_stop;
    logic [c_CH_W-1:0]   w_active;

    always_comb begin
        w_load_clamped = (period_value < c_MIN_PERIOD) ? c_MIN_PERIOD : period_value;
        // A load coinciding with a slot boundary takes effect for the next slot.
        w_next_period  = period_load ? w_load_clamped : r_shadow;
        w_period_last  = r_period - CNT_W'(1);
        w_prev_slot    = (r_slot == '0 || r_slot == c_FINAL_SLOT) ?
                         c_LAST_CH : r_slot - c_SLOT_W'(1);
        w_start        = '0;
        w_stop         = '0;
        if (r_state == c_STROBE) begin
            if (r_slot != c_FINAL_SLOT) begin
                w_start = c_ONE << r_slot;
            end
            if (!r_first) begin
                w_stop = c_ONE << w_prev_slot;
            end
        end
        w_active = (r_slot == c_FINAL_SLOT) ? c_LAST_ACT : r_slot[c_CH_W-1:0];
    end

    // The shadow register belongs to the register-bank side and ignores enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shadow <= c_RESET_PERIOD;
        end else if (period_load) begin
            r_shadow <= w_load_clamped;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_tcnt         <= '0;
            r_period       <= c_RESET_PERIOD;
            r_slot         <= '0;
            r_first        <= 1'b0;
            r_mode         <= 1'b0;
            start_analyzer <= '0;
            stop_analyzer  <= '0;
            active_channel <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (enable) begin
            // Outputs trail the counters by one edge so every output is a flop.
            start_analyzer <= w_start;
            stop_analyzer  <= w_stop;
            done           <= 1'b0;
            if (r_state != c_IDLE) begin
                active_channel <= w_active;
            end
            case (r_state)
                c_IDLE: begin
                    if (continuous || trigger) begin
                        r_state  <= c_STROBE;
                        r_tcnt   <= '0;
                        r_slot   <= '0;
                        r_first  <= 1'b1;
                        r_mode   <= continuous;
                        r_period <= w_next_period;
                        busy     <= 1'b1;
                    end
                end
                c_STROBE: begin
                    r_tcnt <= r_tcnt + CNT_W'(1);
                    if (r_tcnt == c_STROBE_END) begin
                        r_state <= c_GAP;
                    end
                end
                c_GAP: begin
                    if (r_slot == c_FINAL_SLOT) begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (r_tcnt == w_period_last) begin
                        r_tcnt   <= '0;
                        r_period <= w_next_period;
                        r_first  <= 1'b0;
                        r_state  <= c_STROBE;
                        if (r_slot == c_LAST_CH && r_mode) begin
                            r_slot <= '0;
                        end else begin
                            r_slot <= r_slot + c_SLOT_W'(1);
                        end
                    end else begin
                        r_tcnt <= r_tcnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frequency_analyzer_sync_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_frequency_analyzer_sync_multi
// Purpose  : Directed and randomized bench against a timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frequency_analyzer_sync_multi;

    localparam int CH    = 4;
    localparam int SD    = 3;
    localparam int CNT_W = 32;
    localparam int RST_P = 12;

    logic             clock;
    logic             reset;
    logic             enable;
    logic             continuous;
    logic             trigger;
    logic             period_load;
    logic [CNT_W-1:0] period_value;
    logic [CH-1:0]    start_analyzer;
    logic [CH-1:0]    stop_analyzer;
    logic [1:0]       active_channel;
    logic             busy;
    logic             done;

    frequency_analyzer_sync_multi #(
        .CLOCK        (1200),
        .FREQUENCY    (100),
        .CHANNELS     (CH),
        .SIGNAL_DELAY (SD),
        .CNT_W        (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .continuous     (continuous),
        .trigger        (trigger),
        .period_load    (period_load),
        .period_value   (period_value),
        .start_analyzer (start_analyzer),
        .stop_analyzer  (stop_analyzer),
        .active_channel (active_channel),
        .busy           (busy),
        .done           (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cnt = 0;

    // Reference model: run age counts enabled edges since the request; slot k
    // occupies timeline positions [base_k, base_k + P_k) with unbounded k.
    int       m_shadow;
    bit       m_run;
    bit       m_mode;
    int       m_age;
    int       m_base;
    int       m_p;
    int       m_k;
    logic [CH-1:0] e_start;
    logic [CH-1:0] e_stop;
    logic [1:0]    e_act;
    logic          e_busy;
    logic          e_done;

    function automatic int clampv(input int v);
        return (v < SD + 1) ? SD + 1 : v;
    endfunction

    task automatic m_reset();
        m_shadow = RST_P;
        m_run    = 1'b0;
        e_start  = '0;
        e_stop   = '0;
        e_act    = '0;
        e_busy   = 1'b0;
        e_done   = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        int off;
        nxt = period_load ? clampv(int'(period_value)) : m_shadow;
        if (enable) begin
            if (!m_run) begin
                e_start = '0;
                e_stop  = '0;
                e_done  = 1'b0;
                if (continuous || trigger) begin
                    m_run  = 1'b1;
                    m_mode = continuous;
                    m_age  = 0;
                    m_base = 0;
                    m_p    = nxt;
                    m_k    = 0;
                    e_busy = 1'b1;
                end
            end else begin
                m_age++;
                off     = (m_age - 1) - m_base;
                e_done  = 1'b0;
                e_start = '0;
                e_stop  = '0;
                if (!m_mode && m_k == CH && off == SD) begin
                    m_run  = 1'b0;
                    e_busy = 1'b0;
                    e_done = 1'b1;
                    e_act  = 2'(CH - 1);
                end else begin
                    if (off < SD) begin
                        if (m_mode || m_k != CH) e_start[m_k % CH] = 1'b1;
                        if (m_k > 0) e_stop[(m_k - 1) % CH] = 1'b1;
                    end
                    e_act = (!m_mode && m_k == CH) ? 2'(CH - 1) : 2'(m_k % CH);
                    if (m_age == m_base + m_p) begin
                        m_base = m_base + m_p;
                        m_p    = nxt;
                        m_k++;
                    end
                end
            end
        end
        m_shadow = nxt;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("start",  32'(start_analyzer), 32'(e_start));
        chk("stop",   32'(stop_analyzer),  32'(e_stop));
        chk("active", 32'(active_channel), 32'(e_act));
        chk("busy",   32'(busy),           32'(e_busy));
        chk("done",   32'(done),           32'(e_done));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        cyc++;
        @(negedge clock);
        if (done) done_cnt++;
        check_all();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    // Called on a falling edge; reset is asserted between clock edges.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(posedge clock);
        @(negedge clock);
        check_all();
        reset = 1'b0;
    endtask

    task automatic load(input int v);
        period_load  = 1'b1;
        period_value = CNT_W'(v);
        step();
        period_load  = 1'b0;
    endtask

    task automatic begin_run(input logic cont);
        enable     = 1'b1;
        continuous = cont;
        trigger    = ~cont;
        cyc        = -1;
        step();
        trigger    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; continuous = 1'b0; trigger = 1'b0;
        period_load = 1'b0; period_value = '0;
        m_reset();
        @(negedge clock);
        do_reset();

        // Continuous round-robin
        load(10);
        begin_run(1'b1);
        run_to(1);  chk("c_s0", 32'(start_analyzer), 1); chk("c_p0", 32'(stop_analyzer), 0);
        run_to(11); chk("c_s1", 32'(start_analyzer), 2); chk("c_p1", 32'(stop_analyzer), 1);
        run_to(21); chk("c_s2", 32'(start_analyzer), 4); chk("c_p2", 32'(stop_analyzer), 2);
        run_to(31); chk("c_s3", 32'(start_analyzer), 8); chk("c_p3", 32'(stop_analyzer), 4);
        run_to(41); chk("c_wrap_s", 32'(start_analyzer), 1); chk("c_wrap_p", 32'(stop_analyzer), 8);
        run_to(44); chk("c_gap", 32'(start_analyzer), 0); chk("c_busy", 32'(busy), 1);
        continuous = 1'b0;
        do_reset();

        // Single sweep with a trigger while busy, then an immediate re-trigger
        load(10);
        done_cnt = 0;
        begin_run(1'b0);
        run_to(20);
        trigger = 1'b1; step(); trigger = 1'b0;
        run_to(41); chk("s_last_s", 32'(start_analyzer), 0); chk("s_last_p", 32'(stop_analyzer), 8);
        run_to(43); chk("s_last_p3", 32'(stop_analyzer), 8);
        run_to(44); chk("s_done", 32'(done), 1); chk("s_busy", 32'(busy), 0);
        chk("s_done_cnt", 32'(done_cnt), 1);
        trigger = 1'b1; step(); trigger = 1'b0;
        step(); chk("s_retrig", 32'(start_analyzer), 1);
        do_reset();
        // Trigger with enable low in IDLE is dropped
        enable = 1'b0; trigger = 1'b1; step(); trigger = 1'b0; enable = 1'b1;
        step(); step(); step();
        chk("ign_busy", 32'(busy), 0); chk("ign_done_cnt", 32'(done_cnt), 1);
        do_reset();

        // Enable freeze during slot 1 strobe
        load(10);
        begin_run(1'b1);
        run_to(11);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("f_s", 32'(start_analyzer), 2); chk("f_p", 32'(stop_analyzer), 1);
        end
        enable = 1'b1;
        run_to(18); chk("f_tail", 32'(start_analyzer), 2);
        run_to(19); chk("f_off", 32'(start_analyzer), 0);
        run_to(25); chk("f_pre2", 32'(start_analyzer), 0);
        run_to(26); chk("f_s2", 32'(start_analyzer), 4);
        run_to(29); chk("f_s2_off", 32'(start_analyzer), 0);
        continuous = 1'b0;
        do_reset();

        // Mid-slot reload to 20
        load(10);
        begin_run(1'b1);
        run_to(4);
        period_load = 1'b1; period_value = 20; step(); period_load = 1'b0;
        run_to(11); chk("r_s1", 32'(start_analyzer), 2);
        run_to(30); chk("r_gap", 32'(start_analyzer), 0);
        run_to(31); chk("r_s2", 32'(start_analyzer), 4);
        continuous = 1'b0;
        do_reset();

        // Reload below the minimum clamps to SD+1
        load(10);
        begin_run(1'b1);
        run_to(4);
        period_load = 1'b1; period_value = 2; step(); period_load = 1'b0;
        run_to(11); chk("k_s1", 32'(start_analyzer), 2);
        run_to(15); chk("k_s2", 32'(start_analyzer), 4);
        run_to(19); chk("k_s3", 32'(start_analyzer), 8);
        run_to(23); chk("k_wrap", 32'(stop_analyzer), 8);
        continuous = 1'b0;
        do_reset();

        // Asynchronous reset in the middle of a strobe
        load(10);
        begin_run(1'b1);
        run_to(12); chk("a_pre", 32'(start_analyzer), 2);
        continuous = 1'b0;
        reset = 1'b1;
        #1;
        chk("a_start", 32'(start_analyzer), 0);
        chk("a_stop",  32'(stop_analyzer), 0);
        chk("a_busy",  32'(busy), 0);
        do_reset();
        begin_run(1'b1);
        run_to(1); chk("a_re_s", 32'(start_analyzer), 1); chk("a_re_p", 32'(stop_analyzer), 0);
        continuous = 1'b0;
        do_reset();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            enable       = ($urandom_range(0, 99) < 85);
            continuous   = ($urandom_range(0, 3) == 0);
            trigger      = ($urandom_range(0, 9) == 0);
            period_load  = ($urandom_range(0, 19) == 0);
            period_value = CNT_W'($urandom_range(0, 14));
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
